softmax_ifm_tx: RTL and testbench

Transmit-side feeder for the softmax datapath controller. Holds one input feature-map vector of `IFM_SIZE` signed samples, loaded by the host through a simple write port. On a `start` pulse it streams the vector as one contiguous burst on the `valid_ifm`/`ifm` interface, which the softmax controller consumes. It sits between the host/loader and the controller's `valid_ifm`/`ifm` input, and reports progress with `busy`/`done`.

---
 rtl/softmax_pkg.sv | 9 +
 rtl/softmax_ifm_tx_if.sv | 27 ++
 rtl/ifm_buffer.sv | 22 ++
 rtl/softmax_ifm_tx.sv | 71 +++++++
 tb/tb_softmax_ifm_tx.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/softmax_pkg.sv
// softmax_pkg: shared FSM state type and default widths/saturation limits for the softmax datapath
package softmax_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_IFM_SIZE = 1000;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam logic [DEF_DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};
  localparam logic [DEF_DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_DATA_WIDTH-1){1'b1}}};
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, SEND = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/softmax_ifm_tx_if.sv
// softmax_ifm_tx_if: host write/start port and ifm stream bundle; max_val exists only with SOFTMAX_TX_MAXSUB_EN
interface softmax_ifm_tx_if import softmax_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic host_wr;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_data;
  logic start;
  logic valid_ifm;
  logic [DATA_WIDTH-1:0] ifm;
  logic busy;
  logic done;
  logic wr_drop;
`ifdef SOFTMAX_TX_MAXSUB_EN
  logic [DATA_WIDTH-1:0] max_val;
  modport master (output host_wr, host_addr, host_data, start,
                  input valid_ifm, ifm, busy, done, wr_drop, max_val);
  modport slave (input host_wr, host_addr, host_data, start,
                 output valid_ifm, ifm, busy, done, wr_drop, max_val);
`else
  modport master (output host_wr, host_addr, host_data, start,
                  input valid_ifm, ifm, busy, done, wr_drop);
  modport slave (input host_wr, host_addr, host_data, start,
                 output valid_ifm, ifm, busy, done, wr_drop);
`endif
endinterface

// File: rtl/ifm_buffer.sv
// ifm_buffer: simple dual-port sample RAM, registered read with write-first bypass on address collision
module ifm_buffer import softmax_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  // bypass lets a write in the start cycle reach the burst's first sample
  always_comb rd_data_d = (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_q <= rd_data_d;
  end
  assign rd_data = rd_data_q;
endmodule

// File: rtl/softmax_ifm_tx.sv
// softmax_ifm_tx: buffers one ifm vector and streams it as a contiguous valid_ifm burst on start
// Optional SOFTMAX_TX_MAXSUB_EN: tracks max of written samples and sends saturated sample - max.
module softmax_ifm_tx import softmax_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IFM_SIZE   = DEF_IFM_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input logic clk,
  input logic rst,
  softmax_ifm_tx_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(IFM_SIZE - 1);
  localparam logic [ADDR_WIDTH:0] SIZE = (ADDR_WIDTH+1)'(IFM_SIZE);
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, rd_addr;
  logic [DATA_WIDTH-1:0] ifm_q, ifm_d, rd_data, tx_data;
  logic valid_q, valid_d, drop_q, drop_d, wr_ok, emit;
  ifm_buffer #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_buf (
    .clk(clk), .wr_en(wr_ok), .wr_addr(bus.host_addr), .wr_data(bus.host_data),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );
`ifdef SOFTMAX_TX_MAXSUB_EN
  localparam logic [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic [DATA_WIDTH:0] diff;
  always_comb begin
    max_d = (wr_ok && $signed(bus.host_data) > $signed(max_q)) ? bus.host_data : max_q;
    diff = {rd_data[DATA_WIDTH-1], rd_data} - {max_q[DATA_WIDTH-1], max_q};
    tx_data = (diff[DATA_WIDTH] != diff[DATA_WIDTH-1]) ? (diff[DATA_WIDTH] ? S_MIN : S_MAX) : diff[DATA_WIDTH-1:0];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) max_q <= S_MIN;
    else max_q <= max_d;
  assign bus.max_val = max_q;
`else
  assign tx_data = rd_data;
`endif
  // reads run two addresses ahead of cnt_q: one for the RAM register, one for the output register
  always_comb begin
    wr_ok = bus.host_wr && state_q == IDLE && {1'b0, bus.host_addr} < SIZE;
    emit = state_q == READ || (state_q == SEND && cnt_q != LAST);
    rd_addr = state_q == IDLE ? '0 : state_q == READ ? ADDR_WIDTH'(1) : cnt_q + ADDR_WIDTH'(2);
    state_d = state_q == IDLE ? (bus.start ? READ : IDLE) :
              state_q == READ ? SEND :
              state_q == SEND ? (cnt_q == LAST ? DONE : SEND) : IDLE;
    cnt_d = (state_q == SEND && cnt_q != LAST) ? cnt_q + ADDR_WIDTH'(1) : '0;
    valid_d = emit;
    ifm_d = emit ? tx_data : '0;
    drop_d = bus.host_wr && !wr_ok;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      valid_q <= 1'b0;
      ifm_q <= '0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      ifm_q <= ifm_d;
      drop_q <= drop_d;
    end
  assign bus.valid_ifm = valid_q;
  assign bus.ifm = ifm_q;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.wr_drop = drop_q;
endmodule

// File: tb/tb_softmax_ifm_tx.sv
// tb_softmax_ifm_tx: directed bench for softmax_ifm_tx with IFM_SIZE=8
module tb_softmax_ifm_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [15:0] mem_m [8];
  int max_m = -32768;
  always #5 clk = ~clk;
  softmax_ifm_tx_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus ();
  softmax_ifm_tx #(.DATA_WIDTH(16), .IFM_SIZE(8), .ADDR_WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] tx(input int i);
    int d;
    d = $signed(mem_m[i]);
`ifdef SOFTMAX_TX_MAXSUB_EN
    d = d - max_m;
    if (d < -32768) d = -32768;
    if (d > 32767) d = 32767;
`endif
    return d[15:0];
  endfunction

  task automatic model_wr(input logic [3:0] a, input logic [15:0] v);
    if (a < 8) begin
      mem_m[a[2:0]] = v;
      if ($signed(v) > max_m) max_m = $signed(v);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] v);
    bus.host_wr = 1'b1;
    bus.host_addr = a;
    bus.host_data = v;
    tick();
    bus.host_wr = 1'b0;
    model_wr(a, v);
  endtask

  task automatic run_burst(input bit inject, input bit wr0);
    int drops = 0;
    bus.start = 1'b1;
    if (wr0) begin
      bus.host_wr = 1'b1;
      bus.host_addr = 4'd0;
      bus.host_data = 16'h1234;
      model_wr(4'd0, 16'h1234);
    end
    tick();
    bus.start = 1'b0;
    bus.host_wr = 1'b0;
    chk("busy_k1", bus.busy, 1);
    chk("valid_k1", bus.valid_ifm, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("valid_%0d", i), bus.valid_ifm, 1);
      chk($sformatf("ifm_%0d", i), bus.ifm, tx(i));
      chk($sformatf("done_in_%0d", i), bus.done, 0);
      if (bus.wr_drop) drops++;
      if (inject && i == 3) begin
        bus.start = 1'b1;
        bus.host_wr = 1'b1;
        bus.host_addr = 4'd3;
        bus.host_data = 16'h0999;
      end
      if (inject && i == 4) begin
        bus.start = 1'b0;
        bus.host_wr = 1'b0;
      end
      tick();
    end
    chk("done_pulse", bus.done, 1);
    chk("valid_after", bus.valid_ifm, 0);
    chk("ifm_after", bus.ifm, 0);
    chk("busy_at_done", bus.busy, 1);
    if (inject) chk("drop_pulses", drops, 1);
    tick();
    chk("done_clear", bus.done, 0);
    chk("busy_clear", bus.busy, 0);
  endtask

  initial begin
    bus.host_wr = 1'b0;
    bus.host_addr = '0;
    bus.host_data = '0;
    bus.start = 1'b0;
    tick();
    tick();
    chk("rst_valid", bus.valid_ifm, 0);
    chk("rst_ifm", bus.ifm, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_drop", bus.wr_drop, 0);
`ifdef SOFTMAX_TX_MAXSUB_EN
    chk("rst_max", bus.max_val, 16'h8000);
`endif
    rst = 1'b0;
    for (int i = 0; i < 8; i++) wr(4'(i), 16'(10 * i));
    chk("wr_ok_nodrop", bus.wr_drop, 0);
    run_burst(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("no_second_burst", bus.valid_ifm, 0);
      chk("idle_busy", bus.busy, 0);
      tick();
    end
    wr(4'd8, 16'h7777);
    chk("drop_oob", bus.wr_drop, 1);
    tick();
    chk("drop_oob_clear", bus.wr_drop, 0);
    run_burst(1'b0, 1'b1);
    chk("first_is_1234", mem_m[0], 16'h1234);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("pre_rst_valid", bus.valid_ifm, 1);
      chk("pre_rst_ifm", bus.ifm, tx(i));
      tick();
    end
    #2;
    rst = 1'b1;
    max_m = -32768;
    #1;
    chk("midrst_valid", bus.valid_ifm, 0);
    chk("midrst_ifm", bus.ifm, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("midrst_no_done", bus.done, 0);
      tick();
    end
    wr(4'd0, 16'h1234);
    run_burst(1'b0, 1'b0);
`ifdef SOFTMAX_TX_MAXSUB_EN
    rst = 1'b1;
    max_m = -32768;
    tick();
    rst = 1'b0;
    chk("max_after_rst", bus.max_val, 16'h8000);
    wr(4'd0, 16'h8000);
    wr(4'd1, 16'd5);
    wr(4'd2, 16'h7fff);
    for (int i = 3; i < 8; i++) wr(4'(i), 16'(i - 3));
    chk("max_val", bus.max_val, 16'h7fff);
    chk("sat_model0", tx(0), 16'h8000);
    chk("sub_model1", tx(1), 16'h8006);
    run_burst(1'b0, 1'b0);
    chk("max_hold", bus.max_val, 16'h7fff);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
